// File: rtl/beat_timing_gen_if.sv
// Beat/phase bus between the timing generator (slave side) and the hardwired
// controller that consumes the beats and returns short/long/stop (master side).
interface beat_timing_gen_if;
    logic qd_i;
    logic short_i;
    logic long_i;
    logic stop_i;
    logic w1_o;
    logic w2_o;
    logic w3_o;
    logic t1_o;
    logic t2_o;
    logic t3_o;
    logic running_o;
    logic cyc_end_o;

    modport slave (
        input  qd_i, short_i, long_i, stop_i,
        output w1_o, w2_o, w3_o, t1_o, t2_o, t3_o, running_o, cyc_end_o
    );

    modport master (
        output qd_i, short_i, long_i, stop_i,
        input  w1_o, w2_o, w3_o, t1_o, t2_o, t3_o, running_o, cyc_end_o
    );
endinterface

// File: rtl/beat_timing_gen.sv
// Machine-cycle beat (W1..W3) and phase (T1..T3) generator with QD run control.
// Beat/phase outputs come straight from one-hot flops; only cyc_end is combinational.
module beat_timing_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    beat_timing_gen_if.slave        bus
);
    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [2:0] w_q, w_d;
    logic [2:0] t_q, t_d;
    logic [3:0] div_q, div_d;
    logic       div_last;
    logic       beat_end;
    logic [2:0] next_w;

    assign div_last = (div_q == DIV_LAST);
    assign beat_end = (state_q == S_RUN) && t_q[2] && div_last;

    // Controller feedback is only meaningful in the beat-end clock.
    always_comb begin
        next_w = 3'b001;
        if (w_q[0]) begin
            next_w = bus.short_i ? 3'b001 : 3'b010;
        end else if (w_q[1]) begin
            next_w = bus.long_i ? 3'b100 : 3'b001;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        t_d     = t_q;
        div_d   = div_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.qd_i) begin
                    state_d = S_RUN;
                    w_d     = 3'b001;
                    t_d     = 3'b001;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                if (!div_last) begin
                    div_d = div_q + 4'd1;
                end else begin
                    div_d = '0;
                    if (!t_q[2]) begin
                        t_d = {t_q[1:0], 1'b0};
                    end else if (bus.stop_i) begin
                        state_d = S_IDLE;
                        w_d     = '0;
                        t_d     = '0;
                    end else begin
                        t_d = 3'b001;
                        w_d = next_w;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                w_d     = '0;
                t_d     = '0;
                div_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            t_q     <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            t_q     <= t_d;
            div_q   <= div_d;
        end
    end

    assign bus.w1_o      = w_q[0];
    assign bus.w2_o      = w_q[1];
    assign bus.w3_o      = w_q[2];
    assign bus.t1_o      = t_q[0];
    assign bus.t2_o      = t_q[1];
    assign bus.t3_o      = t_q[2];
    assign bus.running_o = (state_q == S_RUN);
    assign bus.cyc_end_o = beat_end && (bus.stop_i
                                        || (w_q[0] && bus.short_i)
                                        || (w_q[1] && !bus.long_i)
                                        || w_q[2]);
endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed bench: dut_a runs with one clock per phase, dut_b with two.
module tb_beat_timing_gen;
    logic clk;
    logic clr_a;
    logic clr_b;
    int   checks;
    int   fails;

    beat_timing_gen_if ifa();
    beat_timing_gen_if ifb();

    beat_timing_gen #(.CLK_DIV(1)) dut_a (.clk(clk), .clr(clr_a), .bus(ifa));
    beat_timing_gen #(.CLK_DIV(2)) dut_b (.clk(clk), .clr(clr_b), .bus(ifb));

    // {running, w3, w2, w1, t3, t2, t1}
    localparam logic [6:0] IDLE = 7'b0_000_000;
    localparam logic [6:0] W1T1 = 7'b1_001_001;
    localparam logic [6:0] W1T2 = 7'b1_001_010;
    localparam logic [6:0] W1T3 = 7'b1_001_100;
    localparam logic [6:0] W2T1 = 7'b1_010_001;
    localparam logic [6:0] W2T2 = 7'b1_010_010;
    localparam logic [6:0] W2T3 = 7'b1_010_100;
    localparam logic [6:0] W3T1 = 7'b1_100_001;
    localparam logic [6:0] W3T2 = 7'b1_100_010;
    localparam logic [6:0] W3T3 = 7'b1_100_100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs_a();
        return {ifa.running_o, ifa.w3_o, ifa.w2_o, ifa.w1_o, ifa.t3_o, ifa.t2_o, ifa.t1_o};
    endfunction

    function automatic logic [6:0] obs_b();
        return {ifb.running_o, ifb.w3_o, ifb.w2_o, ifb.w1_o, ifb.t3_o, ifb.t2_o, ifb.t1_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // At most one beat and one phase may be high on either instance.
    always @(negedge clk) begin
        checks++;
        if ($countones({ifa.w1_o, ifa.w2_o, ifa.w3_o}) > 1 || $countones({ifa.t1_o, ifa.t2_o, ifa.t3_o}) > 1
            || $countones({ifb.w1_o, ifb.w2_o, ifb.w3_o}) > 1 || $countones({ifb.t1_o, ifb.t2_o, ifb.t3_o}) > 1) begin
            fails++;
            $display("FAIL onehot at %0t: a=%b b=%b required at most one w and one t", $time, obs_a(), obs_b());
        end
    end

    task automatic test_reset();
        ifa.qd_i = 0; ifa.short_i = 0; ifa.long_i = 0; ifa.stop_i = 0;
        ifb.qd_i = 0; ifb.short_i = 0; ifb.long_i = 0; ifb.stop_i = 0;
        clr_a = 1; clr_b = 1;
        step();
        step();
        clr_a = 0; clr_b = 0;
        checks++;
        if (obs_a() !== IDLE || ifa.cyc_end_o !== 1'b0) begin
            fails++; $display("FAIL reset_a: got %b ce=%b required %b ce=0", obs_a(), ifa.cyc_end_o, IDLE);
        end
        checks++;
        if (obs_b() !== IDLE || ifb.cyc_end_o !== 1'b0) begin
            fails++; $display("FAIL reset_b: got %b ce=%b required %b ce=0", obs_b(), ifb.cyc_end_o, IDLE);
        end
        step();
        checks++;
        if (obs_a() !== IDLE) begin
            fails++; $display("FAIL idle_hold: got %b required %b", obs_a(), IDLE);
        end
    endtask

    task automatic test_start();
        logic [6:0] exp [4] = '{W1T1, W1T2, W1T3, W2T1};
        ifa.qd_i = 1;
        step();
        ifa.qd_i = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs_a() !== exp[i] || ifa.cyc_end_o !== 1'b0) begin
                fails++; $display("FAIL start[%0d]: got %b ce=%b required %b ce=0", i, obs_a(), ifa.cyc_end_o, exp[i]);
            end
            if (i < 3) step();
        end
    endtask

    // Enters at W2/T1, leaves at W2/T1.
    task automatic test_two_beat();
        logic [6:0] exp [12] = '{W2T1, W2T2, W2T3, W1T1, W1T2, W1T3, W2T1, W2T2, W2T3, W1T1, W1T2, W1T3};
        logic       ce  [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (obs_a() !== exp[i] || ifa.cyc_end_o !== ce[i]) begin
                fails++; $display("FAIL two_beat[%0d]: got %b ce=%b required %b ce=%b", i, obs_a(), ifa.cyc_end_o, exp[i], ce[i]);
            end
            step();
        end
    endtask

    // Enters at W2/T1, leaves at W1/T1.
    task automatic test_short();
        step(); step(); step();
        ifa.short_i = 1;
        for (int i = 0; i < 9; i++) begin
            logic [6:0] e;
            e = (i % 3 == 0) ? W1T1 : (i % 3 == 1) ? W1T2 : W1T3;
            #1;
            checks++;
            if (obs_a() !== e || ifa.cyc_end_o !== (i % 3 == 2)) begin
                fails++; $display("FAIL short[%0d]: got %b ce=%b required %b ce=%b", i, obs_a(), ifa.cyc_end_o, e, (i % 3 == 2));
            end
            step();
        end
        ifa.short_i = 0;
    endtask

    // long held through W1, W2 and W3: ignored in W1 and W3, extends from W2.
    task automatic test_long();
        logic [6:0] exp [10] = '{W1T1, W1T2, W1T3, W2T1, W2T2, W2T3, W3T1, W3T2, W3T3, W1T1};
        logic       ce  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        ifa.long_i = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (obs_a() !== exp[i] || ifa.cyc_end_o !== ce[i]) begin
                fails++; $display("FAIL long[%0d]: got %b ce=%b required %b ce=%b", i, obs_a(), ifa.cyc_end_o, exp[i], ce[i]);
            end
            if (i < 9) step();
        end
        ifa.long_i = 0;
    endtask

    // Enters at W1/T1, leaves at W1/T1.
    task automatic test_stop_restart();
        ifa.stop_i = 1;
        #1;
        checks++;
        if (ifa.cyc_end_o !== 1'b0) begin
            fails++; $display("FAIL stop_early_ce: got %b required 0", ifa.cyc_end_o);
        end
        step();
        ifa.stop_i = 0;
        checks++;
        if (obs_a() !== W1T2) begin
            fails++; $display("FAIL stop_early: got %b required %b", obs_a(), W1T2);
        end
        step(); step(); step(); step();
        ifa.stop_i = 1;
        #1;
        checks++;
        if (obs_a() !== W2T3 || ifa.cyc_end_o !== 1'b1) begin
            fails++; $display("FAIL stop_w2t3: got %b ce=%b required %b ce=1", obs_a(), ifa.cyc_end_o, W2T3);
        end
        step();
        ifa.stop_i = 0;
        checks++;
        if (obs_a() !== IDLE || ifa.cyc_end_o !== 1'b0) begin
            fails++; $display("FAIL stopped: got %b ce=%b required %b ce=0", obs_a(), ifa.cyc_end_o, IDLE);
        end
        step();
        checks++;
        if (obs_a() !== IDLE) begin
            fails++; $display("FAIL stay_idle: got %b required %b", obs_a(), IDLE);
        end
        ifa.qd_i = 1;
        step();
        checks++;
        if (obs_a() !== W1T1) begin
            fails++; $display("FAIL restart: got %b required %b", obs_a(), W1T1);
        end
        // qd still held: ignored while running, then restarts straight after a stop.
        step(); step();
        ifa.short_i = 1; ifa.stop_i = 1;
        #1;
        checks++;
        if (obs_a() !== W1T3 || ifa.cyc_end_o !== 1'b1) begin
            fails++; $display("FAIL qd_run: got %b ce=%b required %b ce=1", obs_a(), ifa.cyc_end_o, W1T3);
        end
        step();
        ifa.short_i = 0; ifa.stop_i = 0;
        checks++;
        if (obs_a() !== IDLE) begin
            fails++; $display("FAIL qd_stop: got %b required %b", obs_a(), IDLE);
        end
        step();
        ifa.qd_i = 0;
        checks++;
        if (obs_a() !== W1T1) begin
            fails++; $display("FAIL qd_held_restart: got %b required %b", obs_a(), W1T1);
        end
    endtask

    task automatic test_reset_mid();
        step(); step(); step(); step(); step();
        ifa.long_i = 1;
        step(); step();
        ifa.long_i = 0;
        checks++;
        if (obs_a() !== W3T2) begin
            fails++; $display("FAIL pre_clr: got %b required %b", obs_a(), W3T2);
        end
        clr_a = 1; ifa.qd_i = 1;
        step();
        clr_a = 0; ifa.qd_i = 0;
        checks++;
        if (obs_a() !== IDLE || ifa.cyc_end_o !== 1'b0) begin
            fails++; $display("FAIL mid_clr: got %b ce=%b required %b ce=0", obs_a(), ifa.cyc_end_o, IDLE);
        end
        step();
        checks++;
        if (obs_a() !== IDLE) begin
            fails++; $display("FAIL post_clr: got %b required %b", obs_a(), IDLE);
        end
    endtask

    task automatic test_div2();
        logic [6:0] exp [19] = '{W1T1, W1T1, W1T2, W1T2, W1T3, W1T3, W2T1, W2T1, W2T2, W2T2,
                                 W2T3, W2T3, W1T1, W1T1, W1T2, W1T2, W1T3, W1T3, W1T1};
        logic       sh  [19] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic       ce  [19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        ifb.qd_i = 1;
        step();
        ifb.qd_i = 0;
        for (int i = 0; i < 19; i++) begin
            ifb.short_i = sh[i];
            #1;
            checks++;
            if (obs_b() !== exp[i] || ifb.cyc_end_o !== ce[i]) begin
                fails++; $display("FAIL div2[%0d]: got %b ce=%b required %b ce=%b", i, obs_b(), ifb.cyc_end_o, exp[i], ce[i]);
            end
            step();
        end
        ifb.short_i = 0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_start();
        test_two_beat();
        test_short();
        test_long();
        test_stop_restart();
        test_reset_mid();
        test_div2();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
